// File: rtl/ddr_timing_pkg.sv
// Shared types and helpers for the per-bank DRAM timing tracker.
// Holds the bank state encoding, strobe count and latency clamp.
package ddr_timing_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ACTIVATING  = 3'd1,
      ST_ACTIVE      = 3'd2,
      ST_READING     = 3'd3,
      ST_WRITING     = 3'd4,
      ST_PRECHARGING = 3'd5,
      ST_REFRESHING  = 3'd6
   } bank_state_t;

   localparam int NCMD = 8;

   // zero latency behaves as a one-cycle latency
   function automatic logic [31:0] lat_clamp(input logic [31:0] v);
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

endpackage

// File: rtl/bank_timing_fsm.sv
// One bank's timing state machine and down-counter.
// go_* strobes arrive decoded; legal flags the presented command.
module bank_timing_fsm
   import ddr_timing_pkg::*;
#(
   parameter int CNTWIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                go_act,
   input  logic                go_rd,
   input  logic                go_rda,
   input  logic                go_wr,
   input  logic                go_wra,
   input  logic                go_pr,
   input  logic                go_pra,
   input  logic                go_ref,
   input  logic [CNTWIDTH-1:0] t_rcd,
   input  logic [CNTWIDTH-1:0] t_rp,
   input  logic [CNTWIDTH-1:0] t_rfc,
   input  logic [CNTWIDTH-1:0] t_cl,
   input  logic [CNTWIDTH-1:0] t_cwl,
   input  logic [CNTWIDTH-1:0] t_bl,
   output bank_state_t         state,
   output logic                busy,
   output logic                legal
);

   localparam int CW1 = CNTWIDTH + 1;

   logic [CNTWIDTH:0]   cnt, nxt_cnt;
   logic [CNTWIDTH:0]   rd_sum, wr_sum;
   logic [CNTWIDTH-1:0] rp_hold, nxt_rp;
   logic                ap, nxt_ap;
   bank_state_t         nxt_state;
   logic                is_idle, is_active, is_timed;

   function automatic logic [CNTWIDTH:0] ld(input logic [CNTWIDTH:0] v);
      return CW1'(lat_clamp(32'(v)) - 32'd1);
   endfunction

   function automatic logic timed(input bank_state_t s);
      return (s != ST_IDLE) && (s != ST_ACTIVE);
   endfunction

   assign rd_sum    = {1'b0, t_cl} + {1'b0, t_bl};
   assign wr_sum    = {1'b0, t_cwl} + {1'b0, t_bl};
   assign is_idle   = (state == ST_IDLE);
   assign is_active = (state == ST_ACTIVE);
   assign is_timed  = timed(state);

   // legality of whatever command is presented this cycle
   always_comb begin
      legal = 1'b1;
      if (go_act) legal = is_idle;
      if (go_rd | go_rda | go_wr | go_wra) legal = is_active;
      if (go_pr) legal = is_idle | is_active;
      if (go_pra) legal = ~is_timed;
      if (go_ref) legal = is_idle;
   end

   // next-state, counter load and auto-precharge bookkeeping
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_ap    = ap;
      nxt_rp    = rp_hold;
      unique case (state)
         ST_IDLE: begin
            if (go_act) begin
               nxt_state = ST_ACTIVATING;
               nxt_cnt   = ld({1'b0, t_rcd});
            end else if (go_ref) begin
               nxt_state = ST_REFRESHING;
               nxt_cnt   = ld({1'b0, t_rfc});
            end
         end
         ST_ACTIVE: begin
            unique case (1'b1)
               go_rd, go_rda: begin
                  nxt_state = ST_READING;
                  nxt_cnt   = ld(rd_sum);
                  nxt_ap    = go_rda;
                  nxt_rp    = t_rp;
               end
               go_wr, go_wra: begin
                  nxt_state = ST_WRITING;
                  nxt_cnt   = ld(wr_sum);
                  nxt_ap    = go_wra;
                  nxt_rp    = t_rp;
               end
               go_pr, go_pra: begin
                  nxt_state = ST_PRECHARGING;
                  nxt_cnt   = ld({1'b0, t_rp});
               end
               default: ;
            endcase
         end
         ST_ACTIVATING: begin
            if (cnt == '0) nxt_state = ST_ACTIVE;
            else nxt_cnt = cnt - 1'b1;
         end
         ST_READING, ST_WRITING: begin
            if (cnt == '0) begin
               if (ap) begin
                  nxt_state = ST_PRECHARGING;
                  nxt_cnt   = ld({1'b0, rp_hold});
                  nxt_ap    = 1'b0;
               end else begin
                  nxt_state = ST_ACTIVE;
               end
            end else begin
               nxt_cnt = cnt - 1'b1;
            end
         end
         ST_PRECHARGING, ST_REFRESHING: begin
            if (cnt == '0) nxt_state = ST_IDLE;
            else nxt_cnt = cnt - 1'b1;
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   // bank state register with busy registered alongside
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         ap      <= 1'b0;
         rp_hold <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= nxt_state;
         cnt     <= nxt_cnt;
         ap      <= nxt_ap;
         rp_hold <= nxt_rp;
         busy    <= timed(nxt_state);
      end
   end

endmodule

// File: rtl/bank_timing_array.sv
// Per-bank DRAM timing tracker: decodes commands to banks,
// checks all-bank legality and reports state and errors.
module bank_timing_array
   import ddr_timing_pkg::*;
#(
   parameter  int BGWIDTH  = 2,
   parameter  int BAWIDTH  = 2,
   parameter  int CNTWIDTH = 8,
   localparam int BW       = BGWIDTH + BAWIDTH,
   localparam int NBANKS   = 2 ** BW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BGWIDTH-1:0]    bg,
   input  logic [BAWIDTH-1:0]    ba,
   input  logic                  ACT,
   input  logic                  RD,
   input  logic                  RDA,
   input  logic                  WR,
   input  logic                  WRA,
   input  logic                  PR,
   input  logic                  PRA,
   input  logic                  REF,
   input  logic [CNTWIDTH-1:0]   tRCD,
   input  logic [CNTWIDTH-1:0]   tRP,
   input  logic [CNTWIDTH-1:0]   tRFC,
   input  logic [CNTWIDTH-1:0]   tCL,
   input  logic [CNTWIDTH-1:0]   tCWL,
   input  logic [CNTWIDTH-1:0]   tBL,
   output logic [NBANKS*3-1:0]   bank_state,
   output logic [NBANKS-1:0]     bank_busy,
   output logic                  cmd_err,
   output logic [BW-1:0]         err_bank
);

   logic [NCMD-1:0]   strb;
   logic [BW-1:0]     idx;
   logic              single, multi, bank_cmd;
   logic              any_timed, all_idle;
   logic              go_pra, go_ref;
   logic              err_now;
   logic [BW-1:0]     err_idx;
   logic [NBANKS-1:0] legal;
   bank_state_t       st [NBANKS];

   assign strb     = {REF, PRA, PR, WRA, WR, RDA, RD, ACT};
   assign idx      = {bg, ba};
   assign single   = ($countones(strb) == 1);
   assign multi    = ($countones(strb) > 1);
   assign bank_cmd = |strb[5:0];

   // all-bank conditions from the registered states
   always_comb begin
      all_idle = 1'b1;
      for (int i = 0; i < NBANKS; i++)
         if (st[i] != ST_IDLE) all_idle = 1'b0;
   end

   assign any_timed = |bank_busy;
   assign go_pra    = single & PRA & ~any_timed;
   assign go_ref    = single & REF & all_idle;

   for (genvar i = 0; i < NBANKS; i++) begin : g_bank
      logic sel;
      assign sel = single & (idx == BW'(i));
      bank_timing_fsm #(.CNTWIDTH(CNTWIDTH)) u_fsm (
         .clk    (clk),
         .rst    (rst),
         .go_act (ACT & sel),
         .go_rd  (RD & sel),
         .go_rda (RDA & sel),
         .go_wr  (WR & sel),
         .go_wra (WRA & sel),
         .go_pr  (PR & sel),
         .go_pra (go_pra),
         .go_ref (go_ref),
         .t_rcd  (tRCD),
         .t_rp   (tRP),
         .t_rfc  (tRFC),
         .t_cl   (tCL),
         .t_cwl  (tCWL),
         .t_bl   (tBL),
         .state  (st[i]),
         .busy   (bank_busy[i]),
         .legal  (legal[i])
      );
      assign bank_state[3*i +: 3] = st[i];
   end

   // error detection against the pre-edge bank states
   always_comb begin
      err_now = multi
              | (single & bank_cmd & ~legal[idx])
              | (single & PRA & any_timed)
              | (single & REF & ~all_idle);
      err_idx = (single & bank_cmd) ? idx : '0;
   end

   // registered error pulse and sticky error bank
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_err  <= 1'b0;
         err_bank <= '0;
      end else begin
         cmd_err <= err_now;
         if (err_now) err_bank <= err_idx;
      end
   end

endmodule

// File: tb/tb_bank_timing_array.sv
// Bench for bank_timing_array: directed plan then random traffic
// compared against a phase-list model of every bank.
module tb_bank_timing_array;

   localparam int NB = 16;
   localparam int S_IDLE = 0, S_ACTG = 1, S_ACTV = 2, S_RD = 3;
   localparam int S_WR = 4, S_PRE = 5, S_REF = 6;
   localparam int C_ACT = 0, C_RD = 1, C_RDA = 2, C_WR = 3;
   localparam int C_WRA = 4, C_PR = 5, C_PRA = 6, C_REF = 7;

   typedef struct {
      int st;
      int dur;
   } ph_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  bg = '0, ba = '0;
   logic [7:0]  strb = '0;
   logic [7:0]  t_rcd = 8'd1, t_rp = 8'd1, t_rfc = 8'd1;
   logic [7:0]  t_cl = 8'd1, t_cwl = 8'd1, t_bl = 8'd1;
   logic [47:0] bank_state;
   logic [15:0] bank_busy;
   logic        cmd_err;
   logic [3:0]  err_bank;

   int checks = 0;
   int errors = 0;

   int  cur [NB];
   int  rem [NB];
   ph_t plan [NB][$];
   bit  m_err;
   int  m_eb;

   bank_timing_array dut (
      .clk        (clk),
      .rst        (rst),
      .bg         (bg),
      .ba         (ba),
      .ACT        (strb[0]),
      .RD         (strb[1]),
      .RDA        (strb[2]),
      .WR         (strb[3]),
      .WRA        (strb[4]),
      .PR         (strb[5]),
      .PRA        (strb[6]),
      .REF        (strb[7]),
      .tRCD       (t_rcd),
      .tRP        (t_rp),
      .tRFC       (t_rfc),
      .tCL        (t_cl),
      .tCWL       (t_cwl),
      .tBL        (t_bl),
      .bank_state (bank_state),
      .bank_busy  (bank_busy),
      .cmd_err    (cmd_err),
      .err_bank   (err_bank)
   );

   always #5 clk = ~clk;

   function automatic int cl1(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin
         cur[b] = S_IDLE;
         rem[b] = 0;
         plan[b].delete();
      end
      m_err = 0;
      m_eb  = 0;
   endtask

   task automatic start(input int b, input int s, input int d,
                        input int s2, input int d2, input int fin);
      cur[b] = s;
      rem[b] = d;
      plan[b].delete();
      if (s2 >= 0) plan[b].push_back('{st: s2, dur: d2});
      plan[b].push_back('{st: fin, dur: 0});
   endtask

   task automatic model_step();
      int  n, c, idx;
      bit  ok, err;
      int  eb;
      ph_t p;
      if (rst) begin
         model_reset();
         return;
      end
      n   = $countones(strb);
      idx = {bg, ba};
      c   = -1;
      for (int k = 0; k < 8; k++) if (strb[k]) c = k;
      err = 0;
      eb  = 0;
      ok  = 1;
      if (n > 1) err = 1;
      else if (n == 1) begin
         case (c)
            C_ACT: ok = (cur[idx] == S_IDLE);
            C_RD, C_RDA, C_WR, C_WRA: ok = (cur[idx] == S_ACTV);
            C_PR: ok = (cur[idx] == S_IDLE) || (cur[idx] == S_ACTV);
            C_PRA: for (int b = 0; b < NB; b++) if (rem[b] > 0) ok = 0;
            default: for (int b = 0; b < NB; b++) if (cur[b] != S_IDLE) ok = 0;
         endcase
         if (!ok) begin
            err = 1;
            eb  = (c < C_PRA) ? idx : 0;
         end
      end
      for (int b = 0; b < NB; b++) begin
         if (rem[b] > 0) begin
            rem[b]--;
            if (rem[b] == 0) begin
               p = plan[b].pop_front();
               cur[b] = p.st;
               rem[b] = p.dur;
            end
         end
      end
      if (n == 1 && !err) begin
         case (c)
            C_ACT: start(idx, S_ACTG, cl1(t_rcd), -1, 0, S_ACTV);
            C_RD:  start(idx, S_RD, cl1(t_cl + t_bl), -1, 0, S_ACTV);
            C_RDA: start(idx, S_RD, cl1(t_cl + t_bl), S_PRE, cl1(t_rp), S_IDLE);
            C_WR:  start(idx, S_WR, cl1(t_cwl + t_bl), -1, 0, S_ACTV);
            C_WRA: start(idx, S_WR, cl1(t_cwl + t_bl), S_PRE, cl1(t_rp), S_IDLE);
            C_PR:  if (cur[idx] == S_ACTV) start(idx, S_PRE, cl1(t_rp), -1, 0, S_IDLE);
            C_PRA: for (int b = 0; b < NB; b++)
                      if (cur[b] == S_ACTV) start(b, S_PRE, cl1(t_rp), -1, 0, S_IDLE);
            default: for (int b = 0; b < NB; b++)
                        start(b, S_REF, cl1(t_rfc), -1, 0, S_IDLE);
         endcase
      end
      m_err = err;
      if (err) m_eb = eb;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [47:0] es;
      logic [15:0] eb;
      for (int b = 0; b < NB; b++) begin
         es[3*b +: 3] = 3'(cur[b]);
         eb[b]        = (rem[b] > 0);
      end
      chk("bank_state", 64'(bank_state), 64'(es));
      chk("bank_busy", 64'(bank_busy), 64'(eb));
      chk("cmd_err", 64'(cmd_err), 64'(m_err));
      chk("err_bank", 64'(err_bank), 64'(m_eb));
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check_all();
      strb = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic issue(input int c, input int b);
      strb      = '0;
      strb[c]   = 1'b1;
      {bg, ba}  = 4'(b);
      step();
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);

      t_rcd = 8'd3;
      issue(C_ACT, 5);
      idle(5);

      issue(C_ACT, 2);
      idle(4);
      t_cl = 8'd4; t_bl = 8'd4; t_rp = 8'd2;
      issue(C_RDA, 2);
      idle(12);

      issue(C_RD, 3);
      idle(2);

      issue(C_PR, 5);
      idle(3);
      t_rfc = 8'd10;
      issue(C_REF, 0);
      idle(3);
      issue(C_REF, 0);
      idle(8);

      issue(C_ACT, 0);
      issue(C_ACT, 7);
      idle(4);
      t_rp = 8'd5;
      issue(C_PRA, 0);
      idle(6);
      strb = 8'b0000_0011;
      {bg, ba} = 4'd4;
      step();
      idle(1);

      t_rcd = 8'd2;
      issue(C_ACT, 9);
      idle(1);
      issue(C_RD, 9);
      idle(2);

      issue(C_ACT, 1);
      idle(3);
      t_cwl = 8'd2; t_bl = 8'd4;
      issue(C_WR, 1);
      idle(2);
      t_cwl = 8'd9;
      idle(5);
      t_cwl = 8'd2;
      issue(C_WR, 1);
      idle(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle(2);

      t_rcd = 8'd0;
      issue(C_ACT, 12);
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         t_rcd = 8'($urandom_range(0, 7));
         t_rp  = 8'($urandom_range(0, 7));
         t_rfc = 8'($urandom_range(0, 12));
         t_cl  = 8'($urandom_range(1, 7));
         t_cwl = 8'($urandom_range(1, 7));
         t_bl  = 8'($urandom_range(1, 8));
         {bg, ba} = 4'($urandom_range(0, 15));
         strb = '0;
         rst  = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 99) < 45) begin
            if ($urandom_range(0, 29) == 0) begin
               strb = 8'($urandom_range(0, 255));
            end else begin
               int c;
               c = $urandom_range(0, 99);
               if (c < 30) strb[C_ACT] = 1'b1;
               else if (c < 90) strb[$urandom_range(1, 5)] = 1'b1;
               else if (c < 95) strb[C_PRA] = 1'b1;
               else strb[C_REF] = 1'b1;
            end
         end
         step();
      end
      rst = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bank_timing_array.md
Name: bank_timing_array

Overview:
- Parametrised per-bank DRAM timing tracker for the DDR emulation path; successor to the fixed-latency per-bank timing FSM array.
- Decodes one command per cycle to the addressed bank ({bg,ba}), or to all banks for PRA/REF.
- Advances each bank's state machine using runtime latency inputs instead of hard-wired constants.
- Flags protocol violations and reports per-bank state and busy status to the command scheduler and the data-path emulator.

Parameters:
- BGWIDTH, 2, bank-group address width.
- BAWIDTH, 2, bank address width within a group.
- CNTWIDTH, 8, width of latency inputs and per-bank down-counters.
- NBANKS, 2**(BGWIDTH+BAWIDTH), derived localparam; total bank count.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset: synchronous, active-high.
- bg  in  BGWIDTH  bank-group address of the current command.
- ba  in  BAWIDTH  bank address of the current command.
- ACT, RD, RDA, WR, WRA, PR  in  1 each  bank-targeted command strobes, one cycle each.
- PRA, REF  in  1 each  all-bank command strobes; bg/ba ignored.
- tRCD, tRP, tRFC, tCL, tCWL, tBL  in  CNTWIDTH each  latencies in clk cycles.
- bank_state  out  NBANKS*3  per-bank state; bank i occupies bits [3i+2:3i].
- bank_busy  out  NBANKS  1 when the bank is in any timed state (not IDLE, not ACTIVE).
- cmd_err  out  1  one-cycle pulse for an illegal or conflicting command.
- err_bank  out  BGWIDTH+BAWIDTH  bank index of the last error; 0 for all-bank errors.

Behaviour:
- Reset: all banks IDLE, all counters 0, bank_busy=0, cmd_err=0, err_bank=0.
  - rst asserted mid-operation aborts all timed states at the next edge.
- State encoding: IDLE=0, ACTIVATING=1, ACTIVE=2, READING=3, WRITING=4, PRECHARGING=5, REFRESHING=6. A per-bank flag records auto-precharge.
- Bank index: {bg,ba}. Only the matching bank sees bank-targeted strobes.
- Latency capture:
  - Latency inputs are sampled into the bank counter in the cycle the command is accepted.
  - Later changes to the inputs do not affect timings already in flight.
  - A latency value of 0 is treated as 1.
- Timed state duration: a timed state lasts exactly N cycles, starting in the cycle after acceptance. The counter is loaded with N-1 and the exit happens on the edge where the counter is 0.
- Transitions (all registered; state changes on the edge after the strobe):
  - IDLE + ACT -> ACTIVATING for tRCD cycles -> ACTIVE.
  - ACTIVE + RD -> READING for tCL+tBL cycles -> ACTIVE.
  - ACTIVE + RDA -> READING for tCL+tBL cycles -> PRECHARGING for tRP cycles -> IDLE.
  - ACTIVE + WR -> WRITING for tCWL+tBL cycles -> ACTIVE.
  - ACTIVE + WRA -> WRITING for tCWL+tBL cycles -> PRECHARGING for tRP cycles -> IDLE.
  - ACTIVE + PR -> PRECHARGING for tRP cycles -> IDLE.
  - IDLE + PR -> legal no-op.
  - PRA: every ACTIVE bank -> PRECHARGING for tRP cycles. IDLE banks stay IDLE. The command is legal only if no bank is in a timed state.
  - REF: legal only if every bank is IDLE; all banks -> REFRESHING for tRFC cycles -> IDLE.
- Sum arithmetic: tCL+tBL and tCWL+tBL are computed at CNTWIDTH+1 bits, and the counter is CNTWIDTH+1 wide internally so the sum cannot wrap.
- Errors:
  - Any command to a bank or state not listed above sets cmd_err=1 in the next cycle; all bank states are unchanged.
  - More than one strobe asserted in the same cycle is also an error; all strobes are ignored.
  - err_bank gets the decoded index for bank-targeted errors and 0 for PRA/REF/multi-strobe errors.
  - A command that arrives on the same edge a bank exits a timed state is judged against the pre-edge state, so it is an error.
- bank_state and bank_busy are registered and track the state exactly.

Decomposition:
- Shared package ddr_timing_pkg:
  - bank_state_t enum (3-bit, encodings above).
  - command-strobe count constant.
  - latency-zero-clamp function.
- Sub-module bank_timing_fsm: one bank's FSM and counter, instantiated NBANKS times in a generate loop.
  - Inputs: decoded per-bank go_* strobes plus latency inputs.
  - Outputs: state and a legality signal.
- The top level performs address decode, the all-bank legality check, error aggregation and output packing.

Test Plan:
- Reset, then ACT to bank 5 with tRCD=3 -> bank_state[5] is ACTIVATING for 3 cycles, then ACTIVE; other banks stay IDLE; cmd_err=0.
- Bank 2 ACTIVE, RDA with tCL=4, tBL=4, tRP=2 -> READING 8 cycles, PRECHARGING 2 cycles, then IDLE; bank_busy[2]=1 throughout those 10 cycles.
- RD to bank 3 while IDLE -> cmd_err pulses once the next cycle, err_bank=3, bank 3 stays IDLE.
- All banks IDLE, REF with tRFC=10 -> all 16 banks REFRESHING for 10 cycles, then IDLE. A second REF while REFRESHING -> cmd_err=1 and the refresh timing is unaffected.
- Banks 0 and 7 ACTIVE, PRA with tRP=5 -> both PRECHARGING 5 cycles, others unchanged. ACT and RD asserted in the same cycle -> cmd_err=1, no state change.
- Bank 1 in WRITING with tCWL=2, tBL=4; tCWL changed to 9 mid-burst -> WRITING still lasts 6 cycles. Assert rst during it -> all outputs reach reset values on the next edge.
